reg_file_rename: RTL

- Architectural register file with per-register rename tags; sits between the Dispatcher and the reorder buffer commit port.
- Holds 32 x 32-bit integer registers. Each register has a busy flag and the RoB index of its youngest in-flight producer.
- Dispatcher reads two source operands (value, or tag if busy) and marks the destination register busy with the new RoB index.
- RoB commit writes the value and clears busy only if the committing index matches the stored tag; a flush clears all busy flags.

---
 rtl/reg_file_rename_if.sv | 59 +++++
 rtl/reg_file_rename.sv | 135 +++++++++++++
 2 files changed

// File: rtl/reg_file_rename_if.sv
// ---------------------------------------------------------------------------
// reg_file_rename_if
// Bundles the Dispatcher read/claim signals, the RoB commit write, the flush
// strobe and the busy counter between the register file and its clients.
//
//   rs1_addr/rs2_addr     source register indices (client -> regfile)
//   rsN_busy/tag/value    operand read results     (regfile -> client)
//   dep_en/reg/index      destination claim        (client -> regfile)
//   commit_en/reg/index/data  RoB commit write     (client -> regfile)
//   flush_in              misprediction flush      (client -> regfile)
//   busy_count            registered busy count    (regfile -> client)
//
// master: Dispatcher/RoB side.  slave: register file side.
// ---------------------------------------------------------------------------
interface reg_file_rename_if #(
    parameter int RoB_WIDTH = 3
);
    logic [4:0]           rs1_addr;
    logic                 rs1_busy;
    logic [RoB_WIDTH-1:0] rs1_tag;
    logic [31:0]          rs1_value;

    logic [4:0]           rs2_addr;
    logic                 rs2_busy;
    logic [RoB_WIDTH-1:0] rs2_tag;
    logic [31:0]          rs2_value;

    logic                 dep_en;
    logic [4:0]           dep_reg;
    logic [RoB_WIDTH-1:0] dep_index;

    logic                 commit_en;
    logic [4:0]           commit_reg;
    logic [RoB_WIDTH-1:0] commit_index;
    logic [31:0]          commit_data;

    logic                 flush_in;
    logic [5:0]           busy_count;

    modport master (
        output rs1_addr, rs2_addr,
        output dep_en, dep_reg, dep_index,
        output commit_en, commit_reg, commit_index, commit_data,
        output flush_in,
        input  rs1_busy, rs1_tag, rs1_value,
        input  rs2_busy, rs2_tag, rs2_value,
        input  busy_count
    );

    modport slave (
        input  rs1_addr, rs2_addr,
        input  dep_en, dep_reg, dep_index,
        input  commit_en, commit_reg, commit_index, commit_data,
        input  flush_in,
        output rs1_busy, rs1_tag, rs1_value,
        output rs2_busy, rs2_tag, rs2_value,
        output busy_count
    );
endinterface

// File: rtl/reg_file_rename.sv
// ---------------------------------------------------------------------------
// reg_file_rename
// Architectural integer register file with per-register rename tags.
// Each register holds a 32-bit value, a busy flag and the RoB index of its
// youngest in-flight producer.
//
// Ports:
//   clk_in    clock, all state updates on the rising edge
//   rst_n_in  asynchronous active-low reset (values, busy, tags, count -> 0)
//   rdy_in    global ready; low freezes all state
//   bus       reg_file_rename_if.slave: two combinational read ports,
//             dispatch claim, RoB commit write, flush, busy_count
//
// Optional build macro: REG_FILE_COMMIT_BYPASS_EN
//   When defined, a read that hits a same-cycle commit which will clear the
//   register's busy flag returns busy 0 and the commit data directly.
//   When undefined, reads reflect registered state only.
// ---------------------------------------------------------------------------
module reg_file_rename #(
    parameter int RoB_WIDTH = 3,
    parameter int REG_NUM   = 32
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               rdy_in,
    reg_file_rename_if.slave   bus
);

    logic [31:0]          value_q [REG_NUM];
    logic [31:0]          value_d [REG_NUM];
    logic                 busy_q  [REG_NUM];
    logic                 busy_d  [REG_NUM];
    logic [RoB_WIDTH-1:0] tag_q   [REG_NUM];
    logic [RoB_WIDTH-1:0] tag_d   [REG_NUM];
    logic [5:0]           busy_count_q;
    logic [5:0]           busy_count_d;

    // -----------------------------------------------------------------------
    // Read ports: identical logic for rs1 (gi=0) and rs2 (gi=1).
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic [4:0]           rd_addr;
        logic                 rd_busy;
        logic [RoB_WIDTH-1:0] rd_tag;
        logic [31:0]          rd_value;

        assign rd_addr = (gi == 0) ? bus.rs1_addr : bus.rs2_addr;

        always_comb begin
            rd_busy  = 1'b0;
            rd_tag   = '0;
            rd_value = '0;
            // x0 is hardwired: never busy, always zero.
            if (rd_addr != 5'd0) begin
                rd_busy  = busy_q[rd_addr];
                rd_tag   = tag_q[rd_addr];
                rd_value = value_q[rd_addr];
`ifdef REG_FILE_COMMIT_BYPASS_EN
                // Forward only a commit that will actually retire this
                // producer; a stale commit leaves the younger claim visible.
                if (rdy_in && bus.commit_en && (bus.commit_reg == rd_addr) &&
                    busy_q[rd_addr] && (tag_q[rd_addr] == bus.commit_index)) begin
                    rd_busy  = 1'b0;
                    rd_value = bus.commit_data;
                end
`endif
            end
        end
    end

    assign bus.rs1_busy   = g_rd[0].rd_busy;
    assign bus.rs1_tag    = g_rd[0].rd_tag;
    assign bus.rs1_value  = g_rd[0].rd_value;
    assign bus.rs2_busy   = g_rd[1].rd_busy;
    assign bus.rs2_tag    = g_rd[1].rd_tag;
    assign bus.rs2_value  = g_rd[1].rd_value;
    assign bus.busy_count = busy_count_q;

    // -----------------------------------------------------------------------
    // Next-state. Priority per register (lowest to highest):
    //   commit clear  <  dispatch claim  <  flush
    // The commit value write is independent of the busy/tag priority.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            value_d[i] = value_q[i];
            busy_d[i]  = busy_q[i];
            tag_d[i]   = tag_q[i];
        end

        if (rdy_in) begin
            // Entry 0 is never written so x0 stays zero and idle.
            for (int i = 1; i < REG_NUM; i++) begin
                if (bus.commit_en && (bus.commit_reg == 5'(i))) begin
                    value_d[i] = bus.commit_data;
                    if (busy_q[i] && (tag_q[i] == bus.commit_index)) begin
                        busy_d[i] = 1'b0;
                    end
                end
                if (bus.dep_en && (bus.dep_reg == 5'(i)) && !bus.flush_in) begin
                    busy_d[i] = 1'b1;
                    tag_d[i]  = bus.dep_index;
                end
                if (bus.flush_in) begin
                    busy_d[i] = 1'b0;
                end
            end
        end

        // Count taken from the post-update flags so it lines up with them.
        busy_count_d = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            busy_count_d = busy_count_d + {5'd0, busy_d[i]};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                busy_q[i]  <= 1'b0;
                tag_q[i]   <= '0;
            end
            busy_count_q <= '0;
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= value_d[i];
                busy_q[i]  <= busy_d[i];
                tag_q[i]   <= tag_d[i];
            end
            busy_count_q <= busy_count_d;
        end
    end

endmodule
